// File: rtl/gain_scaler.sv
// gain_scaler: per-channel programmable fixed-point gain applied to a
// time-multiplexed stream of signed ADC samples, followed by a
// bipolar-to-unipolar offset, saturation and extraction of the upper DAC bits.
//
// Pipeline (one sample per clock, no backpressure):
//   S1  multiply sample by the channel gain (unsigned gain, signed product)
//   S2  drop the fractional gain bits (floor) and add the mid-scale offset
//   S3  clip to the unipolar range and register the DAC code
// in_valid sampled at edge N is seen as out_valid at edge N+3.
//
// Optional build macro:
//   GAIN_SCALER_CLIP_CNT_EN  builds one saturating 16-bit clip counter per
//                            channel, readable through cnt_ch / clip_cnt.
//                            Without it clip_cnt is tied to zero.

module gain_scaler #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 12,
    parameter int GAIN_W   = 8,
    parameter int FRAC_W   = 4,
    parameter int NCH      = 4,
    parameter int CH_W     = $clog2(NCH),
    parameter int GAIN_RST = 64
) (
    input  logic                clk,
    input  logic                rst,
    // sample stream
    input  logic                in_valid,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [IN_W-1:0]     data_in,
    // gain configuration
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [GAIN_W-1:0]   cfg_gain,
    // result stream
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic [OUT_W-1:0]    data_out,
    output logic                out_sat,
    // clip counter read port
    input  logic [CH_W-1:0]     cnt_ch,
    output logic [15:0]         clip_cnt
);

    // Product width: signed sample times zero-extended (hence signed) gain.
    localparam int P_W   = IN_W + GAIN_W + 1;
    // One extra bit so the mid-scale offset add can never wrap.
    localparam int S_W   = P_W + 1;
    // Storage slots cover every encodable channel number; slots at or above
    // NCH are never written and simply hold their reset value.
    localparam int NSLOT = 1 << CH_W;

    localparam logic signed [S_W-1:0] MID_OFFSET = S_W'(2 ** (IN_W - 1));

    // True when a channel index addresses a real channel.
    function automatic logic ch_ok(input logic [CH_W-1:0] ch);
        return ({{(32 - CH_W){1'b0}}, ch} < 32'(NCH));
    endfunction

    // ------------------------------------------------------------------
    // Gain registers
    // ------------------------------------------------------------------
    logic [GAIN_W-1:0] gain_reg [NSLOT];
    logic              cfg_ok;

    assign cfg_ok = cfg_we && ch_ok(cfg_ch);

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_gain
            // Gain entry gi: reset to the default gain, overwritten by a
            // config write addressed to it. A same-cycle sample on this
            // channel still sees the old value, since S1 reads before the edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    gain_reg[gi] <= GAIN_W'(GAIN_RST);
                end else if (cfg_ok && (cfg_ch == CH_W'(gi))) begin
                    gain_reg[gi] <= cfg_gain;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // S1: multiply
    // ------------------------------------------------------------------
    logic [GAIN_W-1:0]     gain_sel;
    logic signed [P_W-1:0] prod_next;
    logic signed [P_W-1:0] prod_reg;
    logic                  s1_valid_reg;
    logic [CH_W-1:0]       s1_ch_reg;

    // Look up the channel gain and form the exact signed product. Both
    // operands are widened to the product width first, so no bits are lost.
    always_comb begin
        gain_sel  = gain_reg[in_ch];
        prod_next = P_W'($signed(data_in)) * P_W'($signed({1'b0, gain_sel}));
    end

    // Capture the product; samples for non-existent channels are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid && ch_ok(in_ch);
        end
        if (in_valid) begin
            prod_reg  <= prod_next;
            s1_ch_reg <= in_ch;
        end
    end

    // ------------------------------------------------------------------
    // S2: scale and offset
    // ------------------------------------------------------------------
    logic signed [P_W-1:0] prod_scaled;
    logic signed [S_W-1:0] sum_next;
    logic signed [S_W-1:0] sum_reg;
    logic                  s2_valid_reg;
    logic [CH_W-1:0]       s2_ch_reg;

    // Arithmetic shift floors toward minus infinity; the offset moves the
    // bipolar range onto 0 .. 2^IN_W-1.
    always_comb begin
        prod_scaled = prod_reg >>> FRAC_W;
        sum_next    = S_W'(prod_scaled) + MID_OFFSET;
    end

    // Register the offset result and carry the channel tag along.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
        end
        if (s1_valid_reg) begin
            sum_reg   <= sum_next;
            s2_ch_reg <= s1_ch_reg;
        end
    end

    // ------------------------------------------------------------------
    // S3: saturate and extract
    // ------------------------------------------------------------------
    logic             sum_neg;
    logic             sum_over;
    logic [OUT_W-1:0] code_next;
    logic             sat_next;

    // Negative sums clip to zero, sums beyond the unipolar range clip to
    // full scale; otherwise keep the top OUT_W bits of the IN_W-bit value.
    always_comb begin
        sum_neg  = sum_reg[S_W-1];
        sum_over = !sum_neg && (|sum_reg[S_W-2:IN_W]);
        if (sum_neg) begin
            code_next = '0;
            sat_next  = 1'b1;
        end else if (sum_over) begin
            code_next = '1;
            sat_next  = 1'b1;
        end else begin
            code_next = sum_reg[IN_W-1 -: OUT_W];
            sat_next  = 1'b0;
        end
    end

    logic             out_valid_reg;
    logic [CH_W-1:0]  out_ch_reg;
    logic [OUT_W-1:0] data_out_reg;
    logic             out_sat_reg;

    // Output registers only change when a valid result leaves S3, so the
    // DAC driver sees stable data between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            data_out_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_ch_reg   <= s2_ch_reg;
                data_out_reg <= code_next;
                out_sat_reg  <= sat_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;
    assign data_out  = data_out_reg;
    assign out_sat   = out_sat_reg;

    // ------------------------------------------------------------------
    // Clip counters
    // ------------------------------------------------------------------
`ifdef GAIN_SCALER_CLIP_CNT_EN
    logic [15:0] clip_reg [NSLOT];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_clip
            // Count clipped results on channel gi, sticking at full scale
            // until the next reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    clip_reg[gi] <= '0;
                end else if (out_valid_reg && out_sat_reg &&
                             (out_ch_reg == CH_W'(gi)) &&
                             (clip_reg[gi] != 16'hFFFF)) begin
                    clip_reg[gi] <= clip_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign clip_cnt = clip_reg[cnt_ch];
`else
    // No counters in this build; the read select has no function.
    logic unused_cnt_ch;

    assign unused_cnt_ch = ^cnt_ch;
    assign clip_cnt      = '0;
`endif

endmodule

// File: doc/gain_scaler.md
# gain_scaler

Parametrised, multi-channel successor to the single-channel 4x ADC-to-DAC passthrough. It applies a per-channel programmable fixed-point gain to a time-multiplexed stream of signed ADC samples. It then converts the result from bipolar to unipolar, saturates it, and emits the upper DAC bits with a valid strobe and channel tag. The block sits between the ADC capture logic and the DAC driver on the 100 MHz system clock.

## Interface
- IN_W, 16, signed ADC sample width
- OUT_W, 12, unsigned DAC code width; must be ≤ IN_W
- GAIN_W, 8, unsigned gain width
- FRAC_W, 4, fractional bits of gain; must be < GAIN_W
- NCH, 4, channel count, ≥ 2; CH_W = $clog2(NCH)
- GAIN_RST, 64, reset gain for every channel (64 = 4.0 with FRAC_W=4)
- clk  in  1  system clock; one clock domain, all logic on its rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  sample strobe
- in_ch  in  CH_W  channel of the sample
- data_in  in  IN_W  signed two's-complement sample
- cfg_we  in  1  gain write strobe
- cfg_ch  in  CH_W  channel to write
- cfg_gain  in  GAIN_W  new gain, unsigned Q(GAIN_W-FRAC_W).FRAC_W
- out_valid  out  1  result strobe
- out_ch  out  CH_W  channel of the result
- data_out  out  OUT_W  unsigned DAC code
- out_sat  out  1  the result was clipped
- cnt_ch  in  CH_W  clip-counter read select
- clip_cnt  out  16  clip count of channel cnt_ch

## Operation
- Gain RAM: NCH registers of GAIN_W bits, all set to GAIN_RST on rst. When cfg_we=1, cfg_gain is written to entry cfg_ch. A write with cfg_ch ≥ NCH is ignored.
- S1 (multiply): when in_valid=1, the block computes the signed product p = data_in × {1'b0, gain[in_ch]}, IN_W+GAIN_W+1 bits wide. It registers in_ch and a valid bit. A sample with in_ch ≥ NCH is dropped and no output is produced for it.
- S2 (scale + offset): s = (p >>> FRAC_W) + 2^(IN_W-1). The shift is arithmetic, so it floors toward −∞. The add is wide enough that it never wraps.
- S3 (saturate + extract):
  - If s < 0: data_out = 0, out_sat = 1.
  - If s > 2^IN_W − 1: data_out = all ones, out_sat = 1.
  - Otherwise: data_out = s[IN_W-1 : IN_W-OUT_W], out_sat = 0.
- The pipeline has no backpressure. Every accepted sample produces exactly one output, in input order.
- If a gain write and a sample hit the same channel on the same cycle, the sample uses the old gain. Samples accepted from the next cycle onward use the new gain.
- out_ch, data_out and out_sat update only when a valid result leaves S3. They hold their values while out_valid = 0.

## Timing
- Latency is 3 cycles: in_valid high at edge N gives out_valid high at edge N+3.
- Throughput is one sample per cycle. Back-to-back samples on the same or different channels are allowed.
- Reset values: out_valid=0, out_ch=0, data_out=0, out_sat=0, clip_cnt=0. All pipeline valid bits are cleared.
- Reset mid-stream discards every sample in flight. The first output after reset comes 3 cycles after the first post-reset in_valid.
- clip_cnt is a combinational read of the register selected by cnt_ch. A write into the counter shows up on the cycle after out_sat.

## Configuration
- GAIN_SCALER_CLIP_CNT_EN defined: each channel has a 16-bit clip counter.
  - It increments when out_valid=1 and out_sat=1 for that channel.
  - It saturates at 0xFFFF and is cleared only by rst.
- GAIN_SCALER_CLIP_CNT_EN undefined: no counter registers are built. clip_cnt is tied to 0 and cnt_ch is unused. The ports remain.

## Test plan
- Default gain after reset:
  - ch0 data_in=0 → data_out=2048, sat=0, out_valid 3 cycles later.
  - data_in=8191 → 4095, sat=0.
  - data_in=−8192 → 0, sat=0.
- Saturation at default gain:
  - data_in=8192 → 4095, sat=1.
  - data_in=−8193 → 0, sat=1.
  - data_in=−32768 → 0, sat=1.
- Gain write to ch2 with cfg_gain=0x18 (1.5):
  - data_in=1000 → s=34268 → data_out=2141.
  - data_in=−3 → p=−72 → −5 after the shift (floor) → data_out=2047.
- Write/sample collision on ch1, changing the gain from 64 to 16 with data_in=4000:
  - The colliding sample → 3048.
  - The next sample → 2298.
  - Back-to-back samples on ch0..ch3 come out in order with the correct out_ch.
- Assert rst while three samples are in flight → no out_valid for 3 cycles. All gains read back as GAIN_RST, verified with data_in=1 → 2048.
- With GAIN_SCALER_CLIP_CNT_EN: 5 clipped samples on ch3 → clip_cnt=5 with cnt_ch=3, 0 on every other channel. Forcing 70000 clips leaves the count held at 0xFFFF. Without the macro, clip_cnt stays 0.
